// File: rtl/rs_pkg.sv
// Shared types, widths and the CDB tag-match helper for the reservation station.
// Operand, opcode, tag and CDB widths are fixed here; the entry struct and the
// match helper are built from these constants.
package rs_pkg;

    localparam int RS_BIT_WIDTH     = 32;
    localparam int RS_OP_WIDTH      = 7;
    localparam int RS_TAG_WIDTH     = 8;
    localparam int RS_NUM_CDB       = 8;
    localparam int RS_NUM_SLOTS     = 4;
    localparam int RS_CDB_IDX_WIDTH = (RS_NUM_CDB > 1) ? $clog2(RS_NUM_CDB) : 1;

    // Tag value meaning "operand value is already present".
    localparam logic [RS_TAG_WIDTH-1:0] NULL_TAG = '0;

    typedef struct packed {
        logic                    valid;
        logic [RS_TAG_WIDTH-1:0] tag;
        logic [RS_OP_WIDTH-1:0]  op;
        logic [RS_TAG_WIDTH-1:0] qj;
        logic [RS_TAG_WIDTH-1:0] qk;
        logic [RS_BIT_WIDTH-1:0] vj;
        logic [RS_BIT_WIDTH-1:0] vk;
    } rs_entry_t;

    typedef struct packed {
        logic                        hit;
        logic [RS_CDB_IDX_WIDTH-1:0] index;
    } cdb_match_t;

    // Finds the lowest-numbered valid CDB channel carrying the given tag.
    // A NULL_TAG never matches, so a zero tag on the bus is harmless.
    function automatic cdb_match_t cdb_match(
        input logic [RS_TAG_WIDTH-1:0]                  tag,
        input logic [RS_NUM_CDB-1:0][RS_TAG_WIDTH-1:0]  cdb_tag,
        input logic [RS_NUM_CDB-1:0]                    cdb_valid
    );
        cdb_match_t result;
        result = '0;
        for (int c = RS_NUM_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && (tag != NULL_TAG) && (cdb_tag[c] == tag)) begin
                result.hit   = 1'b1;
                result.index = RS_CDB_IDX_WIDTH'(c);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: holds an instruction, snoops the CDB for its
// missing operands and reports when both operands are present.
module rs_entry
    import rs_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   flush,
    input  logic                                   alloc,
    input  rs_entry_t                              alloc_entry,
    input  logic                                   issue,
    input  logic [RS_NUM_CDB-1:0][RS_TAG_WIDTH-1:0] cdbTag,
    input  logic [RS_NUM_CDB-1:0][RS_BIT_WIDTH-1:0] cdbVal,
    input  logic [RS_NUM_CDB-1:0]                   cdbValid,
    output rs_entry_t                              state,
    output logic                                   ready
);

    cdb_match_t qj_match;
    cdb_match_t qk_match;

    assign qj_match = cdb_match(state.qj, cdbTag, cdbValid);
    assign qk_match = cdb_match(state.qk, cdbTag, cdbValid);

    // Slot state: squash, load on allocation, drop on issue, capture CDB operands.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= '0;
        end else if (alloc) begin
            state <= alloc_entry;
        end else begin
            if (issue) begin
                state.valid <= 1'b0;
            end
            if (state.valid && qj_match.hit) begin
                state.qj <= NULL_TAG;
                state.vj <= cdbVal[qj_match.index];
            end
            if (state.valid && qk_match.hit) begin
                state.qk <= NULL_TAG;
                state.vk <= cdbVal[qk_match.index];
            end
        end
    end

    assign ready = state.valid && (state.qj == NULL_TAG) && (state.qk == NULL_TAG);

endmodule

// File: rtl/reservation_station.sv
// Multi-slot Tomasulo reservation station: allocates dispatched instructions to
// free slots, tracks relative age, and issues the oldest ready entry to the FU.
module reservation_station
    import rs_pkg::*;
#(
    parameter int BIT_WIDTH    = RS_BIT_WIDTH,
    parameter int ALU_OP_WIDTH = RS_OP_WIDTH,
    parameter int TAG_WIDTH    = RS_TAG_WIDTH,
    parameter int NUM_CDB      = RS_NUM_CDB,
    parameter int NUM_SLOTS    = RS_NUM_SLOTS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              dispVal,
    output logic                              dispRdy,
    input  logic [TAG_WIDTH-1:0]              dispTag,
    input  logic [ALU_OP_WIDTH-1:0]           dispOp,
    input  logic [TAG_WIDTH-1:0]              dispQj,
    input  logic [TAG_WIDTH-1:0]              dispQk,
    input  logic [BIT_WIDTH-1:0]              dispVj,
    input  logic [BIT_WIDTH-1:0]              dispVk,
    input  logic [NUM_CDB-1:0][TAG_WIDTH-1:0] cdbTag,
    input  logic [NUM_CDB-1:0][BIT_WIDTH-1:0] cdbVal,
    input  logic [NUM_CDB-1:0]                cdbValid,
    output logic                              issVal,
    input  logic                              issRdy,
    output logic [TAG_WIDTH-1:0]              issTag,
    output logic [ALU_OP_WIDTH-1:0]           issOp,
    output logic [BIT_WIDTH-1:0]              issVj,
    output logic [BIT_WIDTH-1:0]              issVk,
    output logic [$clog2(NUM_SLOTS):0]        occupancy
);

    localparam int OCC_WIDTH = $clog2(NUM_SLOTS) + 1;
    localparam logic [OCC_WIDTH-1:0] FULL_COUNT = OCC_WIDTH'(NUM_SLOTS);

    rs_entry_t                           slot_state [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]                slot_valid;
    logic [NUM_SLOTS-1:0]                slot_free;
    logic [NUM_SLOTS-1:0]                slot_ready;
    logic [NUM_SLOTS-1:0]                alloc_onehot;
    logic [NUM_SLOTS-1:0]                issue_onehot;
    logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] age_older;
    logic [NUM_SLOTS-1:0][NUM_SLOTS-1:0] older_than;
    logic [OCC_WIDTH-1:0]                occ_count;
    logic                                do_dispatch;
    logic                                do_issue;
    rs_entry_t                           disp_entry;
    cdb_match_t                          disp_qj_match;
    cdb_match_t                          disp_qk_match;

    assign dispRdy     = (occ_count < FULL_COUNT);
    assign occupancy   = occ_count;
    assign issVal      = |slot_ready;
    assign do_dispatch = dispVal & dispRdy & ~flush;
    assign do_issue    = issVal & issRdy & ~flush;

    // Lowest free slot as a one-hot vector (isolate the lowest set bit).
    assign slot_free    = ~slot_valid;
    assign alloc_onehot = slot_free & (~slot_free + NUM_SLOTS'(1));

    assign disp_qj_match = cdb_match(dispQj, cdbTag, cdbValid);
    assign disp_qk_match = cdb_match(dispQk, cdbTag, cdbValid);

    // Build the incoming entry, taking operands straight off the CDB when they arrive this cycle.
    always_comb begin
        disp_entry       = '0;
        disp_entry.valid = 1'b1;
        disp_entry.tag   = dispTag;
        disp_entry.op    = dispOp;
        disp_entry.qj    = disp_qj_match.hit ? NULL_TAG : dispQj;
        disp_entry.vj    = disp_qj_match.hit ? cdbVal[disp_qj_match.index] : dispVj;
        disp_entry.qk    = disp_qk_match.hit ? NULL_TAG : dispQk;
        disp_entry.vk    = disp_qk_match.hit ? cdbVal[disp_qk_match.index] : dispVk;
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        rs_entry u_entry (
            .clk         (clk),
            .reset       (reset),
            .flush       (flush),
            .alloc       (alloc_onehot[g] & do_dispatch),
            .alloc_entry (disp_entry),
            .issue       (issue_onehot[g] & do_issue),
            .cdbTag      (cdbTag),
            .cdbVal      (cdbVal),
            .cdbValid    (cdbValid),
            .state       (slot_state[g]),
            .ready       (slot_ready[g])
        );
        assign slot_valid[g] = slot_state[g].valid;
    end

    // Pick the ready entry that no other ready entry is older than.
    always_comb begin
        older_than   = '0;
        issue_onehot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            for (int j = 0; j < NUM_SLOTS; j++) begin
                older_than[i][j] = age_older[j][i];
            end
            issue_onehot[i] = slot_ready[i] & ~(|(slot_ready & older_than[i]));
        end
    end

    // Drive the issue fields from the selected slot; all zero when nothing is ready.
    always_comb begin
        issTag = '0;
        issOp  = '0;
        issVj  = '0;
        issVk  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (issue_onehot[i]) begin
                issTag = slot_state[i].tag;
                issOp  = slot_state[i].op;
                issVj  = slot_state[i].vj;
                issVk  = slot_state[i].vk;
            end
        end
    end

    // Age matrix: a new entry is younger than every live one; an issued entry leaves no trace.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            age_older <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                for (int j = 0; j < NUM_SLOTS; j++) begin
                    if (do_issue && (issue_onehot[i] || issue_onehot[j])) begin
                        age_older[i][j] <= 1'b0;
                    end else if (do_dispatch && alloc_onehot[j]) begin
                        age_older[i][j] <= slot_valid[i];
                    end else if (do_dispatch && alloc_onehot[i]) begin
                        age_older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // Occupancy tracks dispatches in and issues out.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ_count <= '0;
        end else begin
            occ_count <= occ_count + OCC_WIDTH'(do_dispatch) - OCC_WIDTH'(do_issue);
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus a random
// phase, all compared against an age-ordered queue model of the station.
module tb_reservation_station;

    localparam int BW = 32;
    localparam int OW = 7;
    localparam int TW = 8;
    localparam int NC = 8;
    localparam int NS = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   flush;
    logic                   dispVal;
    logic                   dispRdy;
    logic [TW-1:0]          dispTag;
    logic [OW-1:0]          dispOp;
    logic [TW-1:0]          dispQj;
    logic [TW-1:0]          dispQk;
    logic [BW-1:0]          dispVj;
    logic [BW-1:0]          dispVk;
    logic [NC-1:0][TW-1:0]  cdbTag;
    logic [NC-1:0][BW-1:0]  cdbVal;
    logic [NC-1:0]          cdbValid;
    logic                   issVal;
    logic                   issRdy;
    logic [TW-1:0]          issTag;
    logic [OW-1:0]          issOp;
    logic [BW-1:0]          issVj;
    logic [BW-1:0]          issVk;
    logic [$clog2(NS):0]    occupancy;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending instructions in dispatch order, oldest at index 0.
    typedef struct {
        logic [TW-1:0] tag;
        logic [OW-1:0] op;
        logic [TW-1:0] qj;
        logic [TW-1:0] qk;
        logic [BW-1:0] vj;
        logic [BW-1:0] vk;
    } model_entry_t;

    model_entry_t model[$];

    always #5 clk = ~clk;

    reservation_station dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .dispVal   (dispVal),
        .dispRdy   (dispRdy),
        .dispTag   (dispTag),
        .dispOp    (dispOp),
        .dispQj    (dispQj),
        .dispQk    (dispQk),
        .dispVj    (dispVj),
        .dispVk    (dispVk),
        .cdbTag    (cdbTag),
        .cdbVal    (cdbVal),
        .cdbValid  (cdbValid),
        .issVal    (issVal),
        .issRdy    (issRdy),
        .issTag    (issTag),
        .issOp     (issOp),
        .issVj     (issVj),
        .issVk     (issVk),
        .occupancy (occupancy)
    );

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // Drive the dispatch and issue-handshake inputs for the coming edge.
    task automatic applyStimulus(input logic dv, input logic [TW-1:0] tag, input logic [OW-1:0] op,
                                 input logic [TW-1:0] qj, input logic [TW-1:0] qk,
                                 input logic [BW-1:0] vj, input logic [BW-1:0] vk, input logic ir);
        dispVal = dv;
        dispTag = tag;
        dispOp  = op;
        dispQj  = qj;
        dispQk  = qk;
        dispVj  = vj;
        dispVk  = vk;
        issRdy  = ir;
    endtask

    task automatic setCdb(input int ch, input logic [TW-1:0] tag, input logic [BW-1:0] val);
        cdbTag[ch]   = tag;
        cdbVal[ch]   = val;
        cdbValid[ch] = 1'b1;
    endtask

    task automatic clearCdb();
        cdbTag   = '0;
        cdbVal   = '0;
        cdbValid = '0;
    endtask

    // Value broadcast for a waited-on tag this cycle, lowest channel first; tag 0 never waits.
    task automatic cdbLookup(input logic [TW-1:0] q, output logic hit, output logic [BW-1:0] val);
        hit = 1'b0;
        val = '0;
        if (q != 0) begin
            for (int c = 0; c < NC; c++) begin
                if (!hit && cdbValid[c] && cdbTag[c] == q) begin
                    hit = 1'b1;
                    val = cdbVal[c];
                end
            end
        end
    endtask

    function automatic int firstReady();
        for (int i = 0; i < model.size(); i++) begin
            if (model[i].qj == 0 && model[i].qk == 0) return i;
        end
        return -1;
    endfunction

    // Advance the model across one clock edge using the inputs presented at that edge.
    task automatic modelEdge();
        int           sel;
        int           size0;
        model_entry_t e;
        logic         hit;
        logic [BW-1:0] v;
        if (reset || flush) begin
            model.delete();
        end else begin
            size0 = model.size();
            sel   = firstReady();
            for (int i = 0; i < model.size(); i++) begin
                e = model[i];
                cdbLookup(e.qj, hit, v);
                if (hit) begin
                    e.qj = 0;
                    e.vj = v;
                end
                cdbLookup(e.qk, hit, v);
                if (hit) begin
                    e.qk = 0;
                    e.vk = v;
                end
                model[i] = e;
            end
            if (sel >= 0 && issRdy) model.delete(sel);
            if (dispVal && size0 < NS) begin
                e.tag = dispTag;
                e.op  = dispOp;
                cdbLookup(dispQj, hit, v);
                e.qj = hit ? '0 : dispQj;
                e.vj = hit ? v : dispVj;
                cdbLookup(dispQk, hit, v);
                e.qk = hit ? '0 : dispQk;
                e.vk = hit ? v : dispVk;
                model.push_back(e);
            end
        end
    endtask

    // Compare every output against what the model says the station should show now.
    task automatic compareAll();
        int sel;
        sel = firstReady();
        checkOutput("issVal", issVal, (sel >= 0) ? 1 : 0);
        checkOutput("issTag", issTag, (sel >= 0) ? model[sel].tag : 0);
        checkOutput("issOp",  issOp,  (sel >= 0) ? model[sel].op  : 0);
        checkOutput("issVj",  issVj,  (sel >= 0) ? model[sel].vj  : 0);
        checkOutput("issVk",  issVk,  (sel >= 0) ? model[sel].vk  : 0);
        checkOutput("occupancy", occupancy, model.size());
        checkOutput("dispRdy", dispRdy, (model.size() < NS) ? 1 : 0);
    endtask

    task automatic runCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        compareAll();
    endtask

    task automatic idleCycle(input logic ir);
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, ir);
        runCycle();
    endtask

    // Three entries waiting on tag 0x30 so none can issue before the squash.
    task automatic loadThreeWaiting();
        for (int t = 1; t <= 3; t++) begin
            applyStimulus(1'b1, TW'(t + 40), 7'h01, 8'h30, 8'h00, '0, BW'(t), 1'b0);
            runCycle();
        end
        checkOutput("pre_squash_occ", occupancy, 3);
    endtask

    initial begin
        int expOrder[4];
        reset = 1'b1;
        flush = 1'b0;
        clearCdb();
        applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
        runCycle();
        checkOutput("reset_occ", occupancy, 0);
        checkOutput("reset_dispRdy", dispRdy, 1);
        checkOutput("reset_issVal", issVal, 0);
        reset = 1'b0;

        // Ready-at-dispatch entry issues the next cycle.
        applyStimulus(1'b1, 8'd5, 7'h33, 8'h00, 8'h00, 32'd3, 32'd4, 1'b0);
        runCycle();
        checkOutput("t1_issVal", issVal, 1);
        checkOutput("t1_issTag", issTag, 5);
        checkOutput("t1_issOp",  issOp, 7'h33);
        checkOutput("t1_issVj",  issVj, 3);
        checkOutput("t1_issVk",  issVk, 4);
        checkOutput("t1_occ1",   occupancy, 1);
        idleCycle(1'b1);
        checkOutput("t1_occ0", occupancy, 0);

        // CDB wakeup two cycles after dispatch.
        applyStimulus(1'b1, 8'd7, 7'h01, 8'd9, 8'h00, 32'h0, 32'h1, 1'b0);
        runCycle();
        idleCycle(1'b0);
        checkOutput("t2_waiting", issVal, 0);
        setCdb(2, 8'd9, 32'hAA);
        idleCycle(1'b0);
        clearCdb();
        checkOutput("t2_woken_issVal", issVal, 1);
        checkOutput("t2_woken_issVj", issVj, 32'hAA);
        idleCycle(1'b1);

        // Dispatch-time bypass of a same-cycle broadcast.
        applyStimulus(1'b1, 8'd8, 7'h02, 8'd9, 8'h00, 32'h0, 32'h2, 1'b0);
        setCdb(2, 8'd9, 32'hBB);
        runCycle();
        clearCdb();
        checkOutput("t2_bypass_issVal", issVal, 1);
        checkOutput("t2_bypass_issVj", issVj, 32'hBB);
        idleCycle(1'b1);

        // Fill all slots with waiting entries; a fifth dispatch is ignored.
        for (int t = 1; t <= 4; t++) begin
            applyStimulus(1'b1, TW'(t), 7'h04, TW'(8'h20 + t), 8'h00, 32'h0, BW'(t), 1'b0);
            runCycle();
        end
        checkOutput("t3_full_dispRdy", dispRdy, 0);
        checkOutput("t3_full_occ", occupancy, 4);
        applyStimulus(1'b1, 8'd9, 7'h05, 8'h00, 8'h00, 32'h9, 32'h9, 1'b0);
        runCycle();
        checkOutput("t3_ignored_occ", occupancy, 4);
        checkOutput("t3_ignored_issVal", issVal, 0);

        // Wake youngest first; the oldest ready entry is always the one presented.
        for (int t = 4; t >= 1; t--) begin
            applyStimulus(1'b0, '0, '0, '0, '0, '0, '0, 1'b0);
            setCdb(0, TW'(8'h20 + t), BW'(32'h100 + t));
            runCycle();
            clearCdb();
            checkOutput("t3_wake_issTag", issTag, t);
        end

        // Issue while full: the dispatch is refused, occupancy drops.
        applyStimulus(1'b1, 8'd10, 7'h06, 8'h00, 8'h00, 32'h5, 32'h6, 1'b1);
        runCycle();
        checkOutput("t3_full_issue_occ", occupancy, 3);
        checkOutput("t3_full_issue_next", issTag, 2);

        // Issue and dispatch together below full: occupancy unchanged.
        applyStimulus(1'b1, 8'd11, 7'h07, 8'h00, 8'h00, 32'h5, 32'h6, 1'b1);
        runCycle();
        checkOutput("t3_swap_occ", occupancy, 3);
        expOrder = '{3, 4, 11, 0};
        for (int k = 0; k < 3; k++) begin
            checkOutput("t3_order_issTag", issTag, expOrder[k]);
            idleCycle(1'b1);
        end
        checkOutput("t3_drained_occ", occupancy, 0);

        // Two channels with the same tag: the lower channel's value wins.
        applyStimulus(1'b1, 8'd12, 7'h08, 8'd3, 8'h00, 32'h0, 32'h7, 1'b0);
        runCycle();
        setCdb(1, 8'd3, 32'h11);
        setCdb(6, 8'd3, 32'h66);
        idleCycle(1'b0);
        clearCdb();
        checkOutput("t4_tie_issVj", issVj, 32'h11);
        idleCycle(1'b1);

        // A zero tag on a valid channel never wakes or bypasses anything.
        applyStimulus(1'b1, 8'd13, 7'h09, 8'h00, 8'd5, 32'h55, 32'h0, 1'b0);
        setCdb(0, 8'h00, 32'hDEAD);
        runCycle();
        checkOutput("t4_zero_tag_wait", issVal, 0);
        idleCycle(1'b0);
        checkOutput("t4_zero_tag_still", issVal, 0);
        clearCdb();
        setCdb(3, 8'd5, 32'h77);
        idleCycle(1'b0);
        clearCdb();
        checkOutput("t4_wake_issVj", issVj, 32'h55);
        checkOutput("t4_wake_issVk", issVk, 32'h77);
        idleCycle(1'b1);

        // Flush beats a same-cycle dispatch.
        loadThreeWaiting();
        flush = 1'b1;
        applyStimulus(1'b1, 8'h44, 7'h0A, 8'h00, 8'h00, 32'h1, 32'h2, 1'b0);
        runCycle();
        flush = 1'b0;
        checkOutput("flush_occ", occupancy, 0);
        checkOutput("flush_issVal", issVal, 0);
        checkOutput("flush_dispRdy", dispRdy, 1);
        idleCycle(1'b0);
        checkOutput("flush_nowrite", occupancy, 0);

        // Reset behaves the same way.
        loadThreeWaiting();
        reset = 1'b1;
        applyStimulus(1'b1, 8'h45, 7'h0B, 8'h00, 8'h00, 32'h1, 32'h2, 1'b0);
        runCycle();
        reset = 1'b0;
        checkOutput("reset2_occ", occupancy, 0);
        checkOutput("reset2_issVal", issVal, 0);
        checkOutput("reset2_dispRdy", dispRdy, 1);
        idleCycle(1'b0);
        checkOutput("reset2_nowrite", occupancy, 0);

        // Random traffic with a small tag space so matches, ties and stalls are common.
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(($urandom_range(0, 2) != 0),
                          TW'($urandom_range(1, 15)),
                          OW'($urandom()),
                          ($urandom_range(0, 2) == 0) ? TW'(0) : TW'($urandom_range(1, 15)),
                          ($urandom_range(0, 2) == 0) ? TW'(0) : TW'($urandom_range(1, 15)),
                          $urandom(), $urandom(),
                          ($urandom_range(0, 3) != 0));
            for (int c = 0; c < NC; c++) begin
                cdbValid[c] = ($urandom_range(0, 3) == 0);
                cdbTag[c]   = TW'($urandom_range(0, 15));
                cdbVal[c]   = $urandom();
            end
            flush = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 299) == 0);
            runCycle();
        end
        flush = 1'b0;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
